// File: rtl/roman2bin_dec_pkg.sv
// Shared definitions for the serial Roman-numeral decoder.
// Provides the symbol encoding (same as the bin2roman encoder), width
// constants, the FSM state type and small helper functions.
package roman_pkg;

  localparam int BIT_WIDTH = 6;  // decoded value width
  localparam int OUT_WIDTH = 3;  // symbol code width
  localparam int MAX_LEN   = 7;  // longest legal frame (XXXVIII)
  localparam int ACC_WIDTH = 9;  // holds MAX_LEN * 50

  localparam logic [OUT_WIDTH-1:0] SYM_NULL = 3'b000;
  localparam logic [OUT_WIDTH-1:0] SYM_I    = 3'b001;
  localparam logic [OUT_WIDTH-1:0] SYM_V    = 3'b010;
  localparam logic [OUT_WIDTH-1:0] SYM_X    = 3'b011;
  localparam logic [OUT_WIDTH-1:0] SYM_L    = 3'b100;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Numeric value of a symbol code; NULL and unused codes map to 0.
  function automatic logic [ACC_WIDTH-1:0] sym_value(input logic [OUT_WIDTH-1:0] code);
    logic [ACC_WIDTH-1:0] v;
    case (code)
      SYM_I:   v = 9'd1;
      SYM_V:   v = 9'd5;
      SYM_X:   v = 9'd10;
      SYM_L:   v = 9'd50;
      default: v = 9'd0;
    endcase
    return v;
  endfunction

  // Only IV, IX and XL are canonical subtractive pairs in 0..63.
  function automatic logic pair_ok(input logic [OUT_WIDTH-1:0] sub,
                                   input logic [OUT_WIDTH-1:0] min);
    return ((sub == SYM_I) && ((min == SYM_V) || (min == SYM_X))) ||
           ((sub == SYM_X) && (min == SYM_L));
  endfunction

endpackage

// File: rtl/roman2bin_dec_if.sv
// Symbol-stream input and result output of the Roman decoder.
//   sym_valid/sym/sym_last/sym_ready : last-tagged symbol stream
//   val_valid/val/val_err/val_ready  : decoded result
// slave  = decoder side, master = producer/consumer side.
interface roman2bin_dec_if import roman_pkg::*; ();
  logic                 sym_valid;
  logic [OUT_WIDTH-1:0] sym;
  logic                 sym_last;
  logic                 sym_ready;
  logic                 val_valid;
  logic [BIT_WIDTH-1:0] val;
  logic                 val_err;
  logic                 val_ready;

  modport slave (
    input  sym_valid, sym, sym_last, val_ready,
    output sym_ready, val_valid, val, val_err
  );

  modport master (
    output sym_valid, sym, sym_last, val_ready,
    input  sym_ready, val_valid, val, val_err
  );
endinterface

// File: rtl/roman2bin_dec_sym_val.sv
// Combinational symbol code to value lookup.
//   code         : symbol code
//   value        : numeric value (0 for NULL / unused codes)
//   code_invalid : code lies above SYM_L
module roman_sym_val import roman_pkg::*; (
  input  logic [OUT_WIDTH-1:0] code,
  output logic [ACC_WIDTH-1:0] value,
  output logic                 code_invalid
);
  assign value        = sym_value(code);
  assign code_invalid = (code > SYM_L);
endmodule

// File: rtl/roman2bin_dec.sv
// Serial Roman-numeral decoder: accumulates a last-tagged stream of symbol
// codes into a 6-bit value and flags non-canonical or out-of-range frames.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : symbol stream in / result out (roman2bin_dec_if.slave)
module roman2bin_dec import roman_pkg::*; (
  input logic             clk,
  input logic             rst_n,
  roman2bin_dec_if.slave  bus
);

  localparam logic [ACC_WIDTH-1:0] VAL_MAX = ACC_WIDTH'((1 << BIT_WIDTH) - 1);

  state_t               state_r, state_s;
  logic [ACC_WIDTH-1:0] acc_r, acc_s;
  logic [ACC_WIDTH-1:0] sub_r, sub_s;   // subtrahend of the pair just seen, 0 if none
  logic [OUT_WIDTH-1:0] prev_r, prev_s;
  logic [2:0]           run_r, run_s;
  logic [3:0]           len_r, len_s;
  logic                 err_r, err_s;
  logic [BIT_WIDTH-1:0] val_r, val_s;
  logic                 val_err_r, val_err_s;

  logic [ACC_WIDTH-1:0] v_s, p_s, acc_next_s;
  logic                 code_bad_s, prev_bad_s;
  logic                 ready_s, accept_s, same_s, rise_s;
  logic [2:0]           run_inc_s, run_next_s;
  logic [3:0]           len_next_s;
  logic                 sym_err_s, frame_err_s;

  roman_sym_val u_cur  (.code(bus.sym), .value(v_s), .code_invalid(code_bad_s));
  roman_sym_val u_prev (.code(prev_r),  .value(p_s), .code_invalid(prev_bad_s));

  // sym_ready is low while reset is asserted even though state already reads ACC.
  assign ready_s       = rst_n && (state_r == ACC);
  assign accept_s      = bus.sym_valid && ready_s;
  assign bus.sym_ready = ready_s;
  assign bus.val_valid = (state_r == DONE);
  assign bus.val       = val_r;
  assign bus.val_err   = val_err_r;

  // Per-symbol arithmetic and canonical-form checks.
  always_comb begin
    same_s     = (bus.sym == prev_r);
    run_inc_s  = (run_r == 3'd7) ? 3'd7 : run_r + 3'd1;
    run_next_s = same_s ? run_inc_s : 3'd1;
    len_next_s = (len_r == 4'd15) ? 4'd15 : len_r + 4'd1;
    rise_s     = (prev_r != SYM_NULL) && (v_s > p_s);
    if (rise_s) begin
      acc_next_s = acc_r + v_s - {p_s[ACC_WIDTH-2:0], 1'b0};
    end else begin
      acc_next_s = acc_r + v_s;
    end
    sym_err_s = code_bad_s || prev_bad_s ||
                (bus.sym == SYM_NULL) ||
                (same_s && ((bus.sym == SYM_V) || (bus.sym == SYM_L))) ||
                (run_next_s > 3'd3) ||
                (rise_s && (run_r > 3'd1)) ||
                (rise_s && !pair_ok(prev_r, bus.sym)) ||
                ((sub_r != {ACC_WIDTH{1'b0}}) && (v_s >= sub_r)) ||
                (len_next_s > 4'(MAX_LEN));
    frame_err_s = err_r || sym_err_s || (acc_next_s > VAL_MAX);
  end

  // Next-state and next-register logic of the ACC/DONE FSM.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    sub_s     = sub_r;
    prev_s    = prev_r;
    run_s     = run_r;
    len_s     = len_r;
    err_s     = err_r;
    val_s     = val_r;
    val_err_s = val_err_r;
    case (state_r)
      ACC: begin
        if (accept_s) begin
          prev_s = bus.sym;
          run_s  = run_next_s;
          len_s  = len_next_s;
          err_s  = err_r || sym_err_s;
          // Once the frame has failed, symbols are only drained.
          if (!err_r) begin
            acc_s = acc_next_s;
            sub_s = rise_s ? p_s : {ACC_WIDTH{1'b0}};
          end else begin
            acc_s = acc_r;
          end
          if (bus.sym_last) begin
            state_s   = DONE;
            err_s     = frame_err_s;
            val_err_s = frame_err_s;
            val_s     = frame_err_s ? {BIT_WIDTH{1'b0}} : acc_next_s[BIT_WIDTH-1:0];
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      DONE: begin
        if (bus.val_ready) begin
          state_s   = ACC;
          acc_s     = {ACC_WIDTH{1'b0}};
          sub_s     = {ACC_WIDTH{1'b0}};
          prev_s    = SYM_NULL;
          run_s     = 3'd0;
          len_s     = 4'd0;
          err_s     = 1'b0;
          val_s     = {BIT_WIDTH{1'b0}};
          val_err_s = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = ACC;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ACC;
      acc_r     <= {ACC_WIDTH{1'b0}};
      sub_r     <= {ACC_WIDTH{1'b0}};
      prev_r    <= SYM_NULL;
      run_r     <= 3'd0;
      len_r     <= 4'd0;
      err_r     <= 1'b0;
      val_r     <= {BIT_WIDTH{1'b0}};
      val_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      sub_r     <= sub_s;
      prev_r    <= prev_s;
      run_r     <= run_s;
      len_r     <= len_s;
      err_r     <= err_s;
      val_r     <= val_s;
      val_err_r <= val_err_s;
    end
  end

endmodule

// File: tb/tb_roman2bin_dec.sv
// Directed self-checking bench for roman2bin_dec.
module tb_roman2bin_dec;
  import roman_pkg::*;

  typedef logic [2:0] frame_t [8];

  localparam logic [2:0] N = 3'b000;
  localparam logic [2:0] I = 3'b001;
  localparam logic [2:0] V = 3'b010;
  localparam logic [2:0] X = 3'b011;
  localparam logic [2:0] L = 3'b100;
  localparam logic [2:0] B = 3'b111;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nfail;

  roman2bin_dec_if bus ();

  roman2bin_dec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one symbol and hold it until accepted (bounded wait).
  task automatic send_sym(input logic [2:0] s, input logic last);
    int guard;
    guard = 0;
    bus.sym_valid = 1'b1;
    bus.sym       = s;
    bus.sym_last  = last;
    while (bus.sym_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      nvec++;
      nfail++;
      $display("FAIL sym_accept_timeout: sym_ready=%b required 1", bus.sym_ready);
    end
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
    bus.sym_last  = 1'b0;
  endtask

  // Send a frame of n symbols; return outputs sampled one cycle after the last accept.
  task automatic run_frame(input frame_t f, input int n,
                           output logic vv, output logic [5:0] v, output logic e);
    for (int k = 0; k < n; k++) begin
      send_sym(f[k], (k == n - 1));
    end
    vv = bus.val_valid;
    v  = bus.val;
    e  = bus.val_err;
  endtask

  // Take the result in a single cycle.
  task automatic consume();
    bus.val_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.val_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    nvec++; if (bus.sym_ready !== 1'b0) begin nfail++; $display("FAIL rst_sym_ready: got %b want 0", bus.sym_ready); end
    nvec++; if (bus.val_valid !== 1'b0) begin nfail++; $display("FAIL rst_val_valid: got %b want 0", bus.val_valid); end
    nvec++; if (bus.val !== 6'd0) begin nfail++; $display("FAIL rst_val: got %0d want 0", bus.val); end
    nvec++; if (bus.val_err !== 1'b0) begin nfail++; $display("FAIL rst_val_err: got %b want 0", bus.val_err); end
    #10;
    rst_n = 1'b1;
    #1;
    nvec++; if (bus.sym_ready !== 1'b1) begin nfail++; $display("FAIL rst_release_ready: got %b want 1", bus.sym_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_valid_frames();
    frame_t     f [3];
    int         n [3];
    logic [5:0] exp [3];
    logic       vv, e;
    logic [5:0] v;
    f[0] = '{X, L, I, X, N, N, N, N}; n[0] = 4; exp[0] = 6'd49;
    f[1] = '{L, X, I, I, I, N, N, N}; n[1] = 5; exp[1] = 6'd63;
    f[2] = '{X, X, X, V, I, I, I, N}; n[2] = 7; exp[2] = 6'd38;
    for (int t = 0; t < 3; t++) begin
      run_frame(f[t], n[t], vv, v, e);
      nvec++; if (vv !== 1'b1) begin nfail++; $display("FAIL valid%0d_val_valid: got %b want 1", t, vv); end
      nvec++; if (v !== exp[t]) begin nfail++; $display("FAIL valid%0d_val: got %0d want %0d", t, v, exp[t]); end
      nvec++; if (e !== 1'b0) begin nfail++; $display("FAIL valid%0d_val_err: got %b want 0", t, e); end
      consume();
      nvec++; if (bus.val_valid !== 1'b0) begin nfail++; $display("FAIL valid%0d_cleared: val_valid=%b want 0", t, bus.val_valid); end
      nvec++; if (bus.sym_ready !== 1'b1) begin nfail++; $display("FAIL valid%0d_ready: sym_ready=%b want 1", t, bus.sym_ready); end
    end
  endtask

  task automatic test_error_frames();
    frame_t     f [9];
    int         n [9];
    logic       vv, e;
    logic [5:0] v;
    f[0] = '{I, I, I, V, I, I, I, I}; n[0] = 8;
    f[1] = '{I, I, I, I, N, N, N, N}; n[1] = 4;
    f[2] = '{I, L, N, N, N, N, N, N}; n[2] = 2;
    f[3] = '{V, V, N, N, N, N, N, N}; n[3] = 2;
    f[4] = '{I, I, V, N, N, N, N, N}; n[4] = 3;
    f[5] = '{I, X, I, N, N, N, N, N}; n[5] = 3;
    f[6] = '{L, X, X, X, N, N, N, N}; n[6] = 4;
    f[7] = '{I, B, I, N, N, N, N, N}; n[7] = 3;
    f[8] = '{N, N, N, N, N, N, N, N}; n[8] = 1;
    for (int t = 0; t < 9; t++) begin
      run_frame(f[t], n[t], vv, v, e);
      nvec++; if (vv !== 1'b1) begin nfail++; $display("FAIL err%0d_val_valid: got %b want 1", t, vv); end
      nvec++; if (v !== 6'd0) begin nfail++; $display("FAIL err%0d_val: got %0d want 0", t, v); end
      nvec++; if (e !== 1'b1) begin nfail++; $display("FAIL err%0d_val_err: got %b want 1", t, e); end
      consume();
      nvec++; if (bus.val_err !== 1'b0) begin nfail++; $display("FAIL err%0d_err_cleared: got %b want 0", t, bus.val_err); end
    end
  endtask

  task automatic test_backpressure();
    logic       vv, e;
    logic [5:0] v;
    run_frame('{X, I, V, N, N, N, N, N}, 3, vv, v, e);
    nvec++; if (v !== 6'd14) begin nfail++; $display("FAIL bp_first_val: got %0d want 14", v); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      nvec++; if (bus.val_valid !== 1'b1) begin nfail++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, bus.val_valid); end
      nvec++; if (bus.val !== 6'd14) begin nfail++; $display("FAIL bp_hold_val c%0d: got %0d want 14", c, bus.val); end
      nvec++; if (bus.sym_ready !== 1'b0) begin nfail++; $display("FAIL bp_hold_ready c%0d: got %b want 0", c, bus.sym_ready); end
    end
    bus.val_ready = 1'b1;
    #1;
    nvec++; if (bus.sym_ready !== 1'b0) begin nfail++; $display("FAIL bp_consume_cycle_ready: got %b want 0", bus.sym_ready); end
    @(posedge clk);
    #1;
    bus.val_ready = 1'b0;
    nvec++; if (bus.sym_ready !== 1'b1) begin nfail++; $display("FAIL bp_ready_after: got %b want 1", bus.sym_ready); end
    run_frame('{X, I, X, N, N, N, N, N}, 3, vv, v, e);
    nvec++; if (v !== 6'd19 || e !== 1'b0) begin nfail++; $display("FAIL bp_next_frame: val=%0d err=%b want 19/0", v, e); end
    consume();
  endtask

  task automatic test_idle();
    logic       vv, e;
    logic [5:0] v;
    bus.sym_valid = 1'b0;
    bus.sym       = L;
    bus.sym_last  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (bus.val_valid !== 1'b0) begin nfail++; $display("FAIL idle_val_valid: got %b want 0", bus.val_valid); end
    run_frame('{X, I, N, N, N, N, N, N}, 2, vv, v, e);
    nvec++; if (v !== 6'd11 || e !== 1'b0) begin nfail++; $display("FAIL idle_next_frame: val=%0d err=%b want 11/0", v, e); end
    consume();
  endtask

  task automatic test_reset_midframe();
    logic       vv, e;
    logic [5:0] v;
    send_sym(X, 1'b0);
    send_sym(X, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    nvec++; if (bus.sym_ready !== 1'b0) begin nfail++; $display("FAIL midrst_ready: got %b want 0", bus.sym_ready); end
    nvec++; if (bus.val_valid !== 1'b0 || bus.val !== 6'd0) begin nfail++; $display("FAIL midrst_outputs: valid=%b val=%0d want 0/0", bus.val_valid, bus.val); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame('{I, V, N, N, N, N, N, N}, 2, vv, v, e);
    nvec++; if (v !== 6'd4 || e !== 1'b0 || vv !== 1'b1) begin nfail++; $display("FAIL midrst_next_frame: val=%0d err=%b valid=%b want 4/0/1", v, e, vv); end
    consume();
  endtask

  initial begin
    nvec          = 0;
    nfail         = 0;
    bus.sym_valid = 1'b0;
    bus.sym       = 3'b000;
    bus.sym_last  = 1'b0;
    bus.val_ready = 1'b0;
    test_reset();
    test_valid_frames();
    test_error_frames();
    test_backpressure();
    test_idle();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
